number_entry: RTL and testbench
===============================

NUMBER_ENTRY -- requirements
Module: number_entry

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 digit  input  4  BCD digit from keypad decoder; legal values 0-9.
REQ-004 digit_stb  input  1  one-cycle strobe; digit is sampled when high.
REQ-005 del  input  1  one-cycle strobe; removes the most recently entered digit.
REQ-006 enter  input  1  one-cycle strobe; requests conversion of the entered digits.
REQ-007 clr  input  1  one-cycle strobe; discards the entry in any state.
REQ-008 num_ack  input  1  consumer accepts num while num_valid is high.
REQ-009 num  output  10  binary value of the entered decimal number, 0-999.
REQ-010 num_valid  output  1  num is stable and awaiting num_ack.
REQ-011 display  output  12  three BCD nibbles {hundreds, tens, ones}; an unentered position reads 4'hF (blank).
REQ-012 busy  output  1  high in CONVERT and DONE.

Function
REQ-013 The FSM SHALL have four states: EMPTY (0 digits), ENTRY (1-3 digits), CONVERT, DONE.
REQ-014 Strobe priority in one cycle SHALL be clr > enter > del > digit_stb; lower-priority strobes in that cycle SHALL be dropped.
REQ-015 An accepted digit SHALL shift in at the ones nibble: display <= {display[7:0], digit}; the count increments.
REQ-016 digit_stb SHALL be ignored when digit > 9, when the count = 3, or in CONVERT or DONE.
REQ-017 del SHALL shift display right with 4'hF entering the hundreds nibble; the count decrements; del at count 0 SHALL be ignored.
REQ-018 When the count returns to 0, the state SHALL return to EMPTY and display SHALL read 12'hFFF.
REQ-019 enter in EMPTY SHALL be ignored; enter in ENTRY SHALL move the state to CONVERT with acc = 0 and position = hundreds.
REQ-020 CONVERT SHALL process one nibble per cycle (hundreds, tens, ones): acc <= acc*10 + nibble, with a blank nibble skipped (acc unchanged); after 3 cycles the state SHALL move to DONE.
REQ-021 acc SHALL be 10 bits; 999 is the maximum reachable value, so no overflow handling is required.
REQ-022 Latency: num_valid SHALL rise exactly 3 clocks after the edge that samples enter.
REQ-023 In DONE, num_valid SHALL be 1 and num SHALL hold the result; display SHALL keep the entered digits.
REQ-024 num_ack in DONE SHALL return the state to EMPTY on the next edge, with num_valid = 0 and display = 12'hFFF; num SHALL retain its last value.
REQ-025 num_ack outside DONE SHALL be ignored.
REQ-026 clr in any state, including mid-CONVERT, SHALL force EMPTY on the next edge, with display = 12'hFFF, num_valid = 0 and acc = 0; num SHALL be unchanged.
REQ-027 digit_stb, del and enter SHALL be ignored in CONVERT and DONE.

Reset
REQ-028 While rst_n = 0, the outputs SHALL be: state EMPTY, display 12'hFFF, num 10'd0, num_valid 0, busy 0, count 0, acc 0.
REQ-029 Deassertion of rst_n SHALL take effect at the first rising edge of clk after release; reset mid-CONVERT SHALL abort the conversion without asserting num_valid.

Structure
REQ-030 A shared package SHALL hold the state encoding, BLANK_DIGIT = 4'hF, MAX_DIGITS = 3, and NUM_W = 10, for reuse by the display converter.
REQ-031 A combinational sub-module bcd_mac SHALL compute (acc*10 + nibble) using shift-and-add ((acc<<3)+(acc<<1)+nibble) and SHALL pass acc through unchanged for a blank nibble.

Verification
REQ-032 Type 4,2 then enter -> display 12'hF42 after the second digit; num_valid high 3 clocks after enter; num = 42; num_ack -> display 12'hFFF, num_valid 0.
REQ-033 Type 9,9,9,7 then enter -> the fourth digit is dropped; display 12'h999; num = 999.
REQ-034 Type 1,2,3, del, del, 5, enter -> display sequence 12'h123, 12'hF12, 12'hFF1, 12'hF15; num = 15.
REQ-035 enter in EMPTY; del in EMPTY; digit 4'hC -> no state change; display 12'hFFF; num_valid never asserts.
REQ-036 Type 7, enter, then clr one clock later (mid-CONVERT) -> EMPTY, num_valid stays 0; the same-cycle strobe set clr+enter+digit_stb -> only clr acts.
REQ-037 Type 0,0,8, enter, then hold num_ack low for 10 clocks -> num_valid held with num = 8; async rst_n pulse -> all outputs at reset values immediately.

Source files
------------

// File: rtl/number_entry_pkg.sv
// -----------------------------------------------------------------------------
// number_entry_pkg
// Shared definitions for the keypad number-entry block and anything that
// renders its display (e.g. a seven-segment converter).
//   state_t      : FSM state encoding (EMPTY, ENTRY, CONVERT, DONE)
//   BLANK_DIGIT  : nibble code for an unentered display position
//   MAX_DIGITS   : number of decimal positions that can be entered
//   NUM_W        : width of the converted binary result (0-999)
// -----------------------------------------------------------------------------
package number_entry_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam logic [3:0] MAX_BCD     = 4'd9;
    localparam int         MAX_DIGITS  = 3;
    localparam int         NUM_W       = 10;
    localparam int         DISP_W      = 4 * MAX_DIGITS;

    // Digit count and conversion position both fit in two bits.
    localparam logic [1:0] CNT_MAX  = 2'(MAX_DIGITS);
    localparam logic [1:0] LAST_POS = 2'(MAX_DIGITS - 1);

    // Display value with every position blank.
    function automatic logic [DISP_W-1:0] blank_display();
        return {MAX_DIGITS{BLANK_DIGIT}};
    endfunction

endpackage

// File: rtl/number_entry_if.sv
// -----------------------------------------------------------------------------
// number_entry_if
// Bundles the keypad strobes and the result handshake of number_entry.
//   digit, digit_stb, del, enter, clr : keypad side strobes (master drives)
//   num, num_valid, num_ack           : result handshake (slave presents num)
//   display                           : three BCD nibbles, blank = 4'hF
//   busy                              : high while converting / awaiting ack
// The slave modport is the number_entry block; master is the keypad/consumer.
// -----------------------------------------------------------------------------
interface number_entry_if;
    import number_entry_pkg::*;

    logic [3:0]        digit;
    logic              digit_stb;
    logic              del;
    logic              enter;
    logic              clr;
    logic              num_ack;
    logic [NUM_W-1:0]  num;
    logic              num_valid;
    logic [DISP_W-1:0] display;
    logic              busy;

    modport master (
        output digit, digit_stb, del, enter, clr, num_ack,
        input  num, num_valid, display, busy
    );

    modport slave (
        input  digit, digit_stb, del, enter, clr, num_ack,
        output num, num_valid, display, busy
    );

endinterface

// File: rtl/number_entry_bcd_mac.sv
// -----------------------------------------------------------------------------
// bcd_mac
// Combinational decimal multiply-accumulate step: result = acc*10 + nibble,
// built from shifts and adds (acc*8 + acc*2 + nibble). A blank nibble passes
// acc through so leading blank positions contribute nothing.
//   acc    : running binary accumulator
//   nibble : BCD digit or BLANK_DIGIT
//   result : next accumulator value
// -----------------------------------------------------------------------------
module bcd_mac
    import number_entry_pkg::*;
(
    input  logic [NUM_W-1:0] acc,
    input  logic [3:0]       nibble,
    output logic [NUM_W-1:0] result
);

    logic [NUM_W-1:0] times_ten;

    // Truncation to NUM_W is safe: three digits never exceed 999.
    assign times_ten = (acc << 3) + (acc << 1);

    always_comb begin
        if (nibble == BLANK_DIGIT) begin
            result = acc;
        end else begin
            result = times_ten + NUM_W'(nibble);
        end
    end

endmodule

// File: rtl/number_entry.sv
// -----------------------------------------------------------------------------
// number_entry
// Collects up to three decimal digits from a keypad decoder, shows them on a
// BCD display (shift-in at the ones position), supports delete and clear, and
// on enter converts the digits to binary one nibble per clock. The result is
// held on num with num_valid until the consumer acknowledges it.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : number_entry_if.slave (strobes in; num/num_valid/display/busy out)
// Strobe priority within a cycle: clr > enter > del > digit_stb; a strobe of
// lower priority in the same cycle is dropped even if the higher one is
// itself ignored in the current state.
// -----------------------------------------------------------------------------
module number_entry
    import number_entry_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    number_entry_if.slave   bus
);

    state_t            state_reg,   state_next;
    logic [DISP_W-1:0] display_reg, display_next;
    logic [1:0]        count_reg,   count_next;
    logic [NUM_W-1:0]  acc_reg,     acc_next;
    logic [1:0]        pos_reg,     pos_next;
    logic [NUM_W-1:0]  num_reg,     num_next;

    logic [3:0]        disp_nib [MAX_DIGITS];
    logic [NUM_W-1:0]  mac_result;

    // Split the display into nibbles, index 0 = hundreds, so the conversion
    // position selects digits most-significant first.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = display_reg[(MAX_DIGITS-1-gi)*4 +: 4];
        end
    endgenerate

    bcd_mac u_bcd_mac (
        .acc    (acc_reg),
        .nibble (disp_nib[pos_reg]),
        .result (mac_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_EMPTY;
            display_reg <= blank_display();
            count_reg   <= 2'd0;
            acc_reg     <= '0;
            pos_reg     <= 2'd0;
            num_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            display_reg <= display_next;
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            pos_reg     <= pos_next;
            num_reg     <= num_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        display_next = display_reg;
        count_next   = count_reg;
        acc_next     = acc_reg;
        pos_next     = pos_reg;
        num_next     = num_reg;

        if (bus.clr) begin
            // Abort anything in progress; the last result on num survives.
            state_next   = ST_EMPTY;
            display_next = blank_display();
            count_next   = 2'd0;
            acc_next     = '0;
            pos_next     = 2'd0;
        end else begin
            case (state_reg)
                ST_EMPTY, ST_ENTRY: begin
                    if (bus.enter) begin
                        // With no digits there is nothing to convert.
                        if (state_reg == ST_ENTRY) begin
                            state_next = ST_CONVERT;
                            acc_next   = '0;
                            pos_next   = 2'd0;
                        end
                    end else if (bus.del) begin
                        if (count_reg != 2'd0) begin
                            count_next   = count_reg - 2'd1;
                            display_next = {BLANK_DIGIT, display_reg[DISP_W-1:4]};
                            if (count_reg == 2'd1) begin
                                state_next   = ST_EMPTY;
                                display_next = blank_display();
                            end
                        end
                    end else if (bus.digit_stb) begin
                        if ((bus.digit <= MAX_BCD) && (count_reg < CNT_MAX)) begin
                            display_next = {display_reg[DISP_W-5:0], bus.digit};
                            count_next   = count_reg + 2'd1;
                            state_next   = ST_ENTRY;
                        end
                    end
                end

                ST_CONVERT: begin
                    acc_next = mac_result;
                    pos_next = pos_reg + 2'd1;
                    if (pos_reg == LAST_POS) begin
                        state_next = ST_DONE;
                        num_next   = mac_result;
                    end
                end

                ST_DONE: begin
                    if (bus.num_ack) begin
                        state_next   = ST_EMPTY;
                        display_next = blank_display();
                        count_next   = 2'd0;
                    end
                end

                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.num       = num_reg;
    assign bus.num_valid = (state_reg == ST_DONE);
    assign bus.busy      = (state_reg == ST_CONVERT) || (state_reg == ST_DONE);
    assign bus.display   = display_reg;

endmodule

// File: tb/tb_number_entry.sv
// -----------------------------------------------------------------------------
// tb_number_entry
// Drives number_entry through directed keypad scenarios and a randomized run.
// A reference model holds the entered digits as a queue and the conversion as
// a countdown; each accepted enter pushes {value, due cycle} into a scoreboard
// that a separate monitor pops when num_valid rises.
// -----------------------------------------------------------------------------
module tb_number_entry;
    import number_entry_pkg::*;

    typedef struct {
        int value;
        int due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    number_entry_if bus ();

    number_entry dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model state
    int   m_digits[$];
    int   m_phase;      // 0 = collecting, 1 = converting, 2 = result held
    int   m_left;
    int   m_value;
    int   m_last_num;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int digits_value();
        int v = 0;
        foreach (m_digits[i]) v = v + m_digits[i] * (10 ** (m_digits.size() - 1 - i));
        return v;
    endfunction

    function automatic logic [11:0] exp_display();
        logic [11:0] r = 12'hFFF;
        foreach (m_digits[i]) r[(m_digits.size() - 1 - i) * 4 +: 4] = 4'(m_digits[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        sb.delete();
        m_phase    = 0;
        m_left     = 0;
        m_last_num = 0;
    endtask

    // Applies one cycle of strobes to the model, as of the coming clock edge.
    task automatic model_step(input int d, input bit ds, input bit dl,
                              input bit en, input bit cl, input bit ack);
        if (cl) begin
            if (m_phase == 1) void'(sb.pop_back());
            m_digits.delete();
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase    = 2;
                m_last_num = m_value;
            end
        end else if (m_phase == 2) begin
            if (ack) begin
                m_phase = 0;
                m_digits.delete();
            end
        end else if (en) begin
            if (m_digits.size() > 0) begin
                m_value = digits_value();
                m_phase = 1;
                m_left  = 3;
                sb.push_back('{value: m_value, due: cyc + 4});
            end
        end else if (dl) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (ds) begin
            if (d <= 9 && m_digits.size() < MAX_DIGITS) m_digits.push_back(d);
        end
    endtask

    task automatic step(input int d, input bit ds, input bit dl,
                        input bit en, input bit cl, input bit ack);
        bus.digit     = 4'(d);
        bus.digit_stb = ds;
        bus.del       = dl;
        bus.enter     = en;
        bus.clr       = cl;
        bus.num_ack   = ack;
        model_step(d, ds, dl, en, cl, ack);
        @(posedge clk);
        #1;
        check("display",   int'(bus.display),   int'(exp_display()));
        check("num_valid", int'(bus.num_valid), (m_phase == 2) ? 1 : 0);
        check("busy",      int'(bus.busy),      (m_phase != 0) ? 1 : 0);
        check("num",       int'(bus.num),       m_last_num);
    endtask

    task automatic key(input int d);   step(d, 1, 0, 0, 0, 0); endtask
    task automatic press_enter();      step(0, 0, 0, 1, 0, 0); endtask
    task automatic press_del();        step(0, 0, 1, 0, 0, 0); endtask
    task automatic press_clr();        step(0, 0, 0, 0, 1, 0); endtask
    task automatic ack();              step(0, 0, 0, 0, 0, 1); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_display"},   int'(bus.display),   12'hFFF);
        check({tag, "_num"},       int'(bus.num),       0);
        check({tag, "_num_valid"}, int'(bus.num_valid), 0);
        check({tag, "_busy"},      int'(bus.busy),      0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        $display("reset pulse %s at cycle %0d", tag, cyc);
    endtask

    // Scoreboard monitor: pops an expectation each time num_valid rises.
    initial begin
        bit   prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.num_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_num_valid: got num %0d, required no result (cycle %0d)",
                             bus.num, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result_num", int'(bus.num), e.value);
                    check("result_latency_cycle", cyc, e.due);
                    $display("result num=%0d expected=%0d cycle=%0d", bus.num, e.value, cyc);
                end
            end
            prev_valid = bus.num_valid;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.digit     = 4'd0;
        bus.digit_stb = 1'b0;
        bus.del       = 1'b0;
        bus.enter     = 1'b0;
        bus.clr       = 1'b0;
        bus.num_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4,2 enter, ack
        key(4); key(2);
        check("disp_42", int'(bus.display), 12'hF42);
        press_enter(); idle(3); ack();
        $display("txn 42 done");

        // 9,9,9,7: fourth digit dropped
        key(9); key(9); key(9); key(7);
        check("disp_999", int'(bus.display), 12'h999);
        press_enter(); idle(3); ack();
        $display("txn 999 done");

        // 1,2,3, del, del, 5
        key(1); key(2); key(3); press_del(); press_del(); key(5);
        check("disp_f15", int'(bus.display), 12'hF15);
        press_enter(); idle(3); ack();
        $display("txn 15 done");

        // Ignored strokes in EMPTY
        press_enter(); press_del(); key(12); idle(2);
        $display("txn empty-ignore done");

        // clr mid-CONVERT, then clr+enter+digit in one cycle
        key(7); press_enter(); press_clr(); idle(4);
        key(3); step(5, 1, 0, 1, 1, 0); idle(2);
        // enter in EMPTY drops a same-cycle digit; del drops one too
        step(6, 1, 0, 1, 0, 0); key(2); step(8, 1, 1, 0, 0, 0);
        press_clr();
        $display("txn clr cases done");

        // 0,0,8 held without ack, then async reset
        key(0); key(0); key(8); press_enter(); idle(13);
        check("held_num", int'(bus.num), 8);
        reset_pulse("async");

        // Reset mid-CONVERT aborts without num_valid
        key(5); key(1); press_enter(); idle(1);
        reset_pulse("mid_convert");
        idle(5);

        // Randomized run; num_ack and strokes also land in CONVERT/DONE
        for (int i = 0; i < 500; i++) begin
            int r = $urandom_range(0, 99);
            int d = (($urandom_range(0, 9)) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            step(d, r < 45, (r >= 45 && r < 55) || r == 99, (r >= 55 && r < 67) || r == 98,
                 r < 3 || (r >= 67 && r < 70), (r >= 70 && r < 85) || r == 0);
        end
        idle(2); ack(); idle(6);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
